// File: rtl/signal_addr_gen.sv
// Sample-address generator: walks a signal LUT address once every div_value clocks,
// with a push-button adjustable, saturating divider.
module signal_addr_gen #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned DIV_W    = 16,
    parameter int unsigned DIV_INIT = 1000,
    parameter int unsigned DIV_MIN  = 50,
    parameter int unsigned DIV_MAX  = 5000,
    parameter int unsigned DIV_STEP = 50
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              sw_up,
    input  logic              sw_down,
    output logic              inc_data,
    output logic [ADDR_W-1:0] addr,
    output logic              wrap,
    output logic [DIV_W-1:0]  div_value
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [DIV_W:0] MIN_X  = (DIV_W+1)'(DIV_MIN);
    localparam logic [DIV_W:0] MAX_X  = (DIV_W+1)'(DIV_MAX);
    localparam logic [DIV_W:0] STEP_X = (DIV_W+1)'(DIV_STEP);

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                inc_q, inc_d;
    logic                wrap_q, wrap_d;
    logic [DIV_W:0]      div_ext;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        inc_d   = 1'b0;
        wrap_d  = 1'b0;
        div_d   = div_q;
        div_ext = {1'b0, div_q};

        // One extra bit of headroom keeps both saturation compares free of wrap-around.
        if (sw_up && !sw_down) begin
            if (div_ext < MIN_X + STEP_X) div_d = DIV_W'(DIV_MIN);
            else                          div_d = DIV_W'(div_ext - STEP_X);
        end else if (sw_down && !sw_up) begin
            if (div_ext + STEP_X > MAX_X) div_d = DIV_W'(DIV_MAX);
            else                          div_d = DIV_W'(div_ext + STEP_X);
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (enable) state_d = RUN;
            end
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= div_q - DIV_W'(1)) begin
                    // >= rather than == so a divider decrease below cnt fires next clock.
                    cnt_d  = '0;
                    inc_d  = 1'b1;
                    addr_d = addr_q + ADDR_W'(1);
                    wrap_d = &addr_q;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            inc_q   <= 1'b0;
            wrap_q  <= 1'b0;
            div_q   <= DIV_W'(DIV_INIT);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            inc_q   <= inc_d;
            wrap_q  <= wrap_d;
            div_q   <= div_d;
        end
    end

    assign inc_data  = inc_q;
    assign addr      = addr_q;
    assign wrap      = wrap_q;
    assign div_value = div_q;

endmodule

// File: tb/tb_signal_addr_gen.sv
// Randomised and directed bench for signal_addr_gen against a cycle-level arithmetic model.
module tb_signal_addr_gen;

    localparam int ADDR_W = 10;
    localparam int DIV_W  = 16;
    localparam int DINIT  = 1000;
    localparam int DMIN   = 50;
    localparam int DMAX   = 5000;
    localparam int DSTEP  = 50;
    localparam int NADDR  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic              sw_up = 1'b0;
    logic              sw_down = 1'b0;
    logic              inc_data;
    logic [ADDR_W-1:0] addr;
    logic              wrap;
    logic [DIV_W-1:0]  div_value;

    int vecs = 0;
    int miss = 0;
    int cyc  = 0;

    // Reference model: running flag, clocks elapsed in the current sample period,
    // address, divider and the two strobes.
    bit m_run = 0;
    int m_elapsed = 0;
    int m_addr = 0;
    int m_div = DINIT;
    bit m_inc = 0;
    bit m_wrap = 0;

    signal_addr_gen #(
        .ADDR_W(ADDR_W), .DIV_W(DIV_W), .DIV_INIT(DINIT),
        .DIV_MIN(DMIN), .DIV_MAX(DMAX), .DIV_STEP(DSTEP)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .sw_up(sw_up), .sw_down(sw_down),
        .inc_data(inc_data), .addr(addr), .wrap(wrap), .div_value(div_value)
    );

    always #10 clk = ~clk;

    task automatic tick();
        bit nrun, ninc, nwrap;
        int nel, naddr, nd;
        if (rst) begin
            nrun = 0; nel = 0; naddr = 0; ninc = 0; nwrap = 0; nd = DINIT;
        end else begin
            nd = m_div;
            if (sw_up && !sw_down)  nd = (m_div - DSTEP < DMIN) ? DMIN : m_div - DSTEP;
            if (sw_down && !sw_up)  nd = (m_div + DSTEP > DMAX) ? DMAX : m_div + DSTEP;
            nrun = enable; naddr = m_addr; ninc = 0; nwrap = 0; nel = 0;
            if (m_run && enable) begin
                if (m_elapsed + 1 >= m_div) begin
                    ninc = 1;
                    naddr = (m_addr + 1) % NADDR;
                    nwrap = (naddr == 0);
                end else begin
                    nel = m_elapsed + 1;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        m_run = nrun; m_elapsed = nel; m_addr = naddr; m_inc = ninc; m_wrap = nwrap; m_div = nd;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) begin
            enable = 1'($urandom); sw_up = 1'($urandom); sw_down = 1'($urandom);
            tick();
            vecs++;
            if (inc_data !== 1'b0 || wrap !== 1'b0 || addr !== '0 || div_value !== 16'd1000) begin
                miss++;
                $display("FAIL reset inc=%b wrap=%b addr=%0d div=%0d, want 0 0 0 1000", inc_data, wrap, addr, div_value);
            end
        end
        rst = 1'b0; enable = 1'b0; sw_up = 1'b0; sw_down = 1'b0;
        tick();
    endtask

    task automatic test_default_run();
        int t0, q[$];
        enable = 1'b1;
        t0 = cyc;
        repeat (2100) begin
            tick();
            vecs++;
            if (inc_data !== m_inc || wrap !== m_wrap || addr !== m_addr || div_value !== m_div) begin
                miss++;
                $display("FAIL default_run t=%0d inc=%b/%b wrap=%b/%b addr=%0d/%0d div=%0d/%0d", cyc, inc_data, m_inc, wrap, m_wrap, addr, m_addr, div_value, m_div);
            end
            if (inc_data === 1'b1) q.push_back(cyc - t0);
        end
        // Edge 1 enters RUN; strobes land 1000 and 2000 edges after that.
        vecs++;
        if (q.size() != 2 || q[0] != 1001 || q[1] != 2001 || addr !== 10'd2) begin
            miss++;
            $display("FAIL default_period strobes=%0d first=%0d addr=%0d, want 2 strobes at 1001/2001 addr 2", q.size(), (q.size() > 0) ? q[0] : -1, addr);
        end
    endtask

    task automatic test_sw_up();
        int exp_div, last, n;
        enable = 1'b0;
        tick();
        for (int i = 1; i <= 22; i++) begin
            sw_up = 1'b1; tick(); sw_up = 1'b0;
            exp_div = (DINIT - DSTEP * i < DMIN) ? DMIN : DINIT - DSTEP * i;
            vecs++;
            if (div_value !== exp_div[DIV_W-1:0]) begin
                miss++;
                $display("FAIL sw_up pulse=%0d div=%0d want=%0d", i, div_value, exp_div);
            end
            tick();
        end
        enable = 1'b1;
        last = -1; n = 0;
        repeat (200) begin
            tick();
            if (inc_data === 1'b1) begin
                if (last >= 0) begin
                    vecs++; n++;
                    if (cyc - last != 50) begin
                        miss++;
                        $display("FAIL fast_period got=%0d want=50", cyc - last);
                    end
                end
                last = cyc;
            end
        end
        vecs++;
        if (n < 2) begin
            miss++;
            $display("FAIL fast_period_count got=%0d want>=2", n);
        end
    endtask

    task automatic test_wrap();
        int seen, after;
        seen = 0; after = 0;
        for (int i = 0; i < 52000 && after < 60; i++) begin
            tick();
            vecs++;
            if (inc_data !== m_inc || wrap !== m_wrap || addr !== m_addr || div_value !== m_div) begin
                miss++;
                $display("FAIL wrap_run t=%0d inc=%b/%b wrap=%b/%b addr=%0d/%0d div=%0d/%0d", cyc, inc_data, m_inc, wrap, m_wrap, addr, m_addr, div_value, m_div);
            end
            if (wrap === 1'b1) begin
                seen++;
                vecs++;
                if (inc_data !== 1'b1 || addr !== '0) begin
                    miss++;
                    $display("FAIL wrap_coincide inc=%b addr=%0d want 1 0", inc_data, addr);
                end
            end
            if (seen > 0) after++;
        end
        vecs++;
        if (seen != 1) begin
            miss++;
            $display("FAIL wrap_seen got=%0d want=1", seen);
        end
    endtask

    task automatic test_sw_down();
        int exp_div;
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 1; i <= 90; i++) begin
            enable = 1'($urandom);
            sw_down = 1'b1; tick(); sw_down = 1'b0;
            exp_div = (DINIT + DSTEP * i > DMAX) ? DMAX : DINIT + DSTEP * i;
            vecs++;
            if (div_value !== exp_div[DIV_W-1:0]) begin
                miss++;
                $display("FAIL sw_down pulse=%0d div=%0d want=%0d", i, div_value, exp_div);
            end
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    task automatic test_both_and_decrease();
        int since, found;
        rst = 1'b1; tick(); rst = 1'b0; enable = 1'b0;
        sw_up = 1'b1; sw_down = 1'b1; tick(); sw_up = 1'b0; sw_down = 1'b0;
        vecs++;
        if (div_value !== 16'd1000) begin
            miss++;
            $display("FAIL both_pressed div=%0d want=1000", div_value);
        end
        enable = 1'b1;
        tick();
        since = 0;
        repeat (900) begin tick(); since++; end
        sw_up = 1'b1; tick(); since++; sw_up = 1'b0;
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            tick(); since++;
            vecs++;
            if (inc_data !== m_inc || addr !== m_addr || div_value !== m_div) begin
                miss++;
                $display("FAIL decrease_run inc=%b/%b addr=%0d/%0d div=%0d/%0d", inc_data, m_inc, addr, m_addr, div_value, m_div);
            end
            if (inc_data === 1'b1) found = since;
        end
        vecs++;
        if (found != 950) begin
            miss++;
            $display("FAIL decrease_strobe clocks_after_run=%0d want=950", found);
        end
    endtask

    task automatic test_reset_mid();
        int n, hold;
        bit hit;
        rst = 1'b1; tick(); rst = 1'b0; enable = 1'b0;
        repeat (8) begin sw_up = 1'b1; tick(); sw_up = 1'b0; tick(); end
        enable = 1'b1;
        hit = 0;
        for (int i = 0; i < 6000 && !hit; i++) begin
            tick();
            vecs++;
            if (inc_data !== m_inc || addr !== m_addr || div_value !== m_div) begin
                miss++;
                $display("FAIL pre_reset inc=%b/%b addr=%0d/%0d div=%0d/%0d", inc_data, m_inc, addr, m_addr, div_value, m_div);
            end
            hit = (m_addr == 7 && m_elapsed == 500);
        end
        vecs++;
        if (!hit) begin
            miss++;
            $display("FAIL reach_mid addr=%0d want=7 within budget", addr);
        end
        rst = 1'b1; tick(); rst = 1'b0;
        vecs++;
        if (addr !== '0 || div_value !== 16'd1000 || inc_data !== 1'b0) begin
            miss++;
            $display("FAIL mid_reset addr=%0d div=%0d inc=%b, want 0 1000 0", addr, div_value, inc_data);
        end
        n = 0;
        for (int i = 0; i < 1100; i++) begin
            tick();
            if (n == 0 && inc_data === 1'b1) n = i + 1;
        end
        vecs++;
        if (n != 1001) begin
            miss++;
            $display("FAIL post_reset_strobe edge=%0d want=1001", n);
        end
        enable = 1'b0;
        tick();
        hold = addr;
        repeat (100) begin
            tick();
            vecs++;
            if (inc_data !== 1'b0 || addr !== hold[ADDR_W-1:0]) begin
                miss++;
                $display("FAIL frozen inc=%b addr=%0d want 0 %0d", inc_data, addr, hold);
            end
        end
    endtask

    task automatic test_random();
        repeat (2500) begin
            enable  = ($urandom_range(0, 99) < 92);
            sw_up   = ($urandom_range(0, 24) == 0);
            sw_down = ($urandom_range(0, 24) == 0);
            rst     = ($urandom_range(0, 599) == 0);
            tick();
            vecs++;
            if (inc_data !== m_inc || wrap !== m_wrap || addr !== m_addr || div_value !== m_div) begin
                miss++;
                $display("FAIL random t=%0d inc=%b/%b wrap=%b/%b addr=%0d/%0d div=%0d/%0d", cyc, inc_data, m_inc, wrap, m_wrap, addr, m_addr, div_value, m_div);
            end
        end
        rst = 1'b0; sw_up = 1'b0; sw_down = 1'b0;
    endtask

    initial begin
        test_reset();
        test_default_run();
        test_sw_up();
        test_wrap();
        test_sw_down();
        test_both_and_decrease();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule

// File: doc/signal_addr_gen.md
SIGNAL_ADDR_GEN -- requirements
Module: signal_addr_gen

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, sample address width (1024 LUT entries).
REQ-002 SHALL have parameter DIV_W, default 16, divider register width.
REQ-003 SHALL have parameter DIV_INIT, default 1000, divider value after reset, in clocks per sample.
REQ-004 SHALL have parameter DIV_MIN, default 50, fastest allowed divider.
REQ-005 SHALL have parameter DIV_MAX, default 5000, slowest allowed divider.
REQ-006 SHALL have parameter DIV_STEP, default 50, divider change per button pulse.
REQ-007 SHALL have port clk  input  1  system clock (50 MHz); all logic on the rising edge.
REQ-008 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-009 SHALL have port enable  input  1  run request; low freezes address generation.
REQ-010 SHALL have port sw_up  input  1  single-cycle "faster" pulse from the debounced KEY[0] path.
REQ-011 SHALL have port sw_down  input  1  single-cycle "slower" pulse from the debounced KEY[1] path.
REQ-012 SHALL have port inc_data  output  1  single-cycle strobe marking each new sample address.
REQ-013 SHALL have port addr  output  ADDR_W  read address into the signal memory.
REQ-014 SHALL have port wrap  output  1  single-cycle strobe when addr steps from 2^ADDR_W-1 to 0.
REQ-015 SHALL have port div_value  output  DIV_W  current divider, for display on LEDs/HEX.

Function
REQ-016 SHALL implement a two-state FSM: IDLE (enable=0) and RUN (enable=1).
REQ-017 SHALL transition IDLE->RUN on the first clock with enable=1, and RUN->IDLE on the first clock with enable=0.
REQ-018 SHALL, in IDLE, hold addr, hold cnt at 0, and drive inc_data=0 and wrap=0.
REQ-019 SHALL, in RUN, increment an internal counter cnt each clock.
REQ-020 SHALL, in RUN, when cnt >= div_value-1, clear cnt to 0, assert inc_data for exactly one cycle and, on the same edge, advance addr by 1.
REQ-021 SHALL therefore produce inc_data with a period of exactly div_value clocks in steady state; the first strobe comes div_value clocks after entering RUN.
REQ-022 SHALL wrap addr modulo 2^ADDR_W, and SHALL assert wrap in the same cycle as the inc_data that sets addr to 0.
REQ-023 SHALL, on sw_up=1 and sw_down=0, set div_value = max(div_value-DIV_STEP, DIV_MIN), effective the next clock.
REQ-024 SHALL, on sw_down=1 and sw_up=0, set div_value = min(div_value+DIV_STEP, DIV_MAX), effective the next clock.
REQ-025 SHALL leave div_value unchanged when sw_up and sw_down are both 1 in the same cycle.
REQ-026 SHALL compute the saturation without overflow or underflow at the DIV_W width; results outside [DIV_MIN, DIV_MAX] SHALL never appear.
REQ-027 SHALL accept divider changes in both IDLE and RUN.
REQ-028 SHALL, when a divider decrease makes cnt >= div_value-1, fire inc_data on the next clock; no cycle SHALL be skipped or doubled.
REQ-029 SHALL treat a sw pulse longer than one cycle as one step per cycle asserted; upstream guarantees single-cycle pulses.

Reset
REQ-030 SHALL, while rst=1, set the FSM to IDLE, cnt=0, addr=0, inc_data=0, wrap=0 and div_value=DIV_INIT, regardless of the other inputs.
REQ-031 SHALL, when rst asserts mid-period, discard the partial count; the first inc_data after rst deassertion (with enable=1) comes a full DIV_INIT clocks later.

Verification
REQ-032 Scenario: reset, enable=1 with defaults -> inc_data every 1000 clocks; addr 0,1,2,... and the first strobe 1000 clocks after enable.
REQ-033 Scenario: 20 sw_up pulses from reset -> div_value 1000,950,...,50, then held at 50 for pulses 20+; inc_data period 50.
REQ-034 Scenario: 90 sw_down pulses from reset -> div_value saturates at 5000; no overflow.
REQ-035 Scenario: div_value=50 over 1024 strobes -> addr goes 1023->0 with wrap=1 for one cycle, coincident with inc_data.
REQ-036 Scenario: sw_up and sw_down in the same cycle -> div_value unchanged; then cnt=900 with div 1000 plus an sw_up to 950 -> strobe at cnt=949.
REQ-037 Scenario: rst pulse at cnt=500, addr=7 -> addr=0 and div_value=1000 next clock; the next strobe 1000 clocks after release; enable=0 mid-run -> addr frozen with no strobes.
